// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for ram_multi_read_port
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int MIN_READ_PORTS = 1;
  localparam int MAX_READ_PORTS = 8;

  // Counter/index width for a MEM_SIZE-word array; never narrower than one bit.
  function automatic int clear_cnt_width(input int mem_size);
    return (mem_size <= 2) ? 1 : $clog2(mem_size);
  endfunction

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// rtl/ram_clear_sequencer.sv - CLEAR/READY FSM walking every address after reset or on request
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int MEM_SIZE = 256,
  parameter int CNT_W    = clear_cnt_width(MEM_SIZE)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iClear,
  output logic [CNT_W-1:0] oClearAddr,
  output logic             oClearWe,
  output logic             oReady
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_SIZE - 1);

  ram_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             ready_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      we_q    <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (iClear) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            we_q    <= 1'b1;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign oClearAddr = cnt_q;
  assign oClearWe   = we_q;
  assign oReady     = ready_q;

endmodule

// File: rtl/ram_multi_read_port.sv
// rtl/ram_multi_read_port.sv - N-read/1-write RAM with clear sequencer; RAM_BYPASS_EN selects write-first reads
module ram_multi_read_port
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    MEM_SIZE    = 256,
  parameter int                    READ_PORTS  = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic                                 iClear,
  input  logic                                 iWriteEnable,
  input  logic [ADDR_WIDTH-1:0]                iWriteAddress,
  input  logic signed [DATA_WIDTH-1:0]         iDataIn,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]     iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0]     oDataOut,
  output logic                                 oReady,
  output logic                                 oAddrError
);

  localparam int                  CNT_W     = clear_cnt_width(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  logic [DATA_WIDTH-1:0]            ram_q [MEM_SIZE];
  logic [READ_PORTS*DATA_WIDTH-1:0] dout_q;
  logic [READ_PORTS*DATA_WIDTH-1:0] dout_d;
  logic [READ_PORTS-1:0]            port_err;
  logic                             err_q;
  logic [CNT_W-1:0]                 clr_addr;
  logic                             clr_we;
  logic                             ready;
  logic                             wr_in_range;
  logic                             wr_accept;

  ram_clear_sequencer #(
    .MEM_SIZE (MEM_SIZE),
    .CNT_W    (CNT_W)
  ) u_clear_seq (
    .Clock      (Clock),
    .Reset      (Reset),
    .iClear     (iClear),
    .oClearAddr (clr_addr),
    .oClearWe   (clr_we),
    .oReady     (ready)
  );

  assign wr_in_range = ({1'b0, iWriteAddress} < MEM_LIMIT);
  assign wr_accept   = ready & iWriteEnable & wr_in_range;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] word;

    assign addr        = iReadAddress[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
    assign in_range    = ({1'b0, addr} < MEM_LIMIT);
    assign port_err[k] = ~in_range;

    always_comb begin
      word = '0;
      if (in_range) begin
        word = ram_q[CNT_W'(addr)];
      end
`ifdef RAM_BYPASS_EN
      // Forward the word being written so a same-cycle reader sees new data.
      if (in_range && wr_accept && (addr == iWriteAddress)) begin
        word = iDataIn;
      end
`endif
    end

    assign dout_d[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = word;
  end

  // The array itself carries no reset; the clear sequencer initialises it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (clr_we) begin
        ram_q[clr_addr] <= CLEAR_VALUE;
      end else if (wr_accept) begin
        ram_q[CNT_W'(iWriteAddress)] <= iDataIn;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || !ready) begin
      dout_q <= '0;
      err_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      err_q  <= (|port_err) | (iWriteEnable & ~wr_in_range);
    end
  end

  assign oDataOut   = dout_q;
  assign oReady     = ready;
  assign oAddrError = err_q;

endmodule
